// File: rtl/frame_buffer_streamer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vfx_video_pkg : shared video types for the frame buffer streamer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package vfx_video_pkg;

    localparam int FRAME_W    = 320;
    localparam int FRAME_H    = 240;
    localparam int NUM_PIXELS = FRAME_W * FRAME_H;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int RGB444_BITS = $bits(rgb444_t);

    typedef struct packed {
        logic    sop;
        logic    eop;
        rgb444_t rgb;
    } pix_beat_t;

    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_buffer_streamer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_buffer_streamer_if : ready/valid pixel stream with SOP/EOP |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface frame_buffer_streamer_if
    import vfx_video_pkg::*;
#(
    parameter int PIXEL_BITS = RGB444_BITS
) ();

    logic [PIXEL_BITS-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/frame_buffer_streamer_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_fifo : shift-register sync FIFO, head entry is a flop     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module stream_fifo
    import vfx_video_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          push,
    input  wire pix_beat_t     push_beat,
    input  wire logic          pop,
    output pix_beat_t          head,
    output logic               full,
    output logic               empty,
    output logic [CNT_BITS-1:0] count
);

    pix_beat_t           mem_q [DEPTH];
    pix_beat_t           mem_d [DEPTH];
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;
    logic [CNT_BITS-1:0] fill;
    logic                do_push;
    logic                do_pop;

    // Entries shift toward slot 0 on pop, so the head is always mem_q[0].
    always_comb begin
        do_pop  = pop & (count_q != '0);
        do_push = push & ((count_q != CNT_BITS'(DEPTH)) | do_pop);
        mem_d   = mem_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        fill = count_q - CNT_BITS'(do_pop);
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fill == CNT_BITS'(i)) begin
                    mem_d[i] = push_beat;
                end
            end
        end
        count_d = fill + CNT_BITS'(do_push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[0];
    assign full  = (count_q == CNT_BITS'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_streamer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_buffer_streamer : raster-order BRAM reader -> pixel stream |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module frame_buffer_streamer
    import vfx_video_pkg::*;
#(
    parameter int NUM_PIXELS = vfx_video_pkg::NUM_PIXELS,
    parameter int PIXEL_BITS = 12,
    parameter int ADDR_BITS  = 17,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    output logic                       rd_en,
    output logic [ADDR_BITS-1:0]       rd_addr,
    output logic                       rd_bank,
    input  wire logic [PIXEL_BITS-1:0] rd_data,
    input  wire logic                  swap_req,
    output logic                       swap_ack,
    frame_buffer_streamer_if.master    out_if
);

    localparam int                   C_CNT_BITS  = $clog2(FIFO_DEPTH + 1);
    localparam int                   C_OCC_BITS  = C_CNT_BITS + 1;
    localparam logic [ADDR_BITS-1:0] C_LAST_ADDR = ADDR_BITS'(NUM_PIXELS - 1);

    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  inflight_q, inflight_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic                  swap_ack_q, swap_ack_d;
    swap_state_t           swap_state_q, swap_state_d;

    logic                  issue;
    logic                  issue_last;
    logic                  pop;
    logic                  push;
    logic [C_OCC_BITS-1:0] occupancy;
    pix_beat_t             push_beat;
    pix_beat_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [C_CNT_BITS-1:0] fifo_count;

    // Reads are issued only while FIFO + in-flight slot has room after this cycle's pop.
    always_comb begin
        pop        = !fifo_empty & out_if.out_ready;
        occupancy  = {1'b0, fifo_count} + C_OCC_BITS'(inflight_q) - C_OCC_BITS'(pop);
        issue      = !reset && (occupancy < C_OCC_BITS'(FIFO_DEPTH));
        issue_last = issue && (rd_addr_q == C_LAST_ADDR);

        rd_addr_d = rd_addr_q;
        if (issue) begin
            rd_addr_d = issue_last ? '0 : rd_addr_q + ADDR_BITS'(1);
        end
        inflight_d = issue;
        sop_d      = (rd_addr_q == '0);
        eop_d      = (rd_addr_q == C_LAST_ADDR);
    end

    // The bank only toggles on the read that closes a frame.
    always_comb begin
        swap_state_d = swap_state_q;
        rd_bank_d    = rd_bank_q;
        swap_ack_d   = 1'b0;
        case (swap_state_q)
            SWAP_IDLE: begin
                if (swap_req) begin
                    if (issue_last) begin
                        rd_bank_d  = ~rd_bank_q;
                        swap_ack_d = 1'b1;
                    end else begin
                        swap_state_d = SWAP_PENDING;
                    end
                end
            end
            SWAP_PENDING: begin
                if (issue_last) begin
                    rd_bank_d    = ~rd_bank_q;
                    swap_ack_d   = 1'b1;
                    swap_state_d = SWAP_IDLE;
                end
            end
            default: swap_state_d = SWAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q    <= '0;
            rd_bank_q    <= 1'b0;
            inflight_q   <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            swap_ack_q   <= 1'b0;
            swap_state_q <= SWAP_IDLE;
        end else begin
            rd_addr_q    <= rd_addr_d;
            rd_bank_q    <= rd_bank_d;
            inflight_q   <= inflight_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            swap_ack_q   <= swap_ack_d;
            swap_state_q <= swap_state_d;
        end
    end

    always_comb begin
        push          = inflight_q & (!fifo_full | pop);
        push_beat     = '0;
        push_beat.sop = sop_q;
        push_beat.eop = eop_q;
        push_beat.rgb = rgb444_t'(rd_data);
    end

    stream_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .CNT_BITS (C_CNT_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_en            = issue;
    assign rd_addr          = rd_addr_q;
    assign rd_bank          = rd_bank_q;
    assign swap_ack         = swap_ack_q;
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head.rgb;
    assign out_if.out_sop   = head.sop;
    assign out_if.out_eop   = head.eop;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_streamer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_frame_buffer_streamer : random-ready bench with frame model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_frame_buffer_streamer;
    import vfx_video_pkg::*;

    localparam int N     = 64;
    localparam int AB    = 7;
    localparam int PB    = 12;
    localparam int DEPTH = 2;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          swap_req = 1'b0;
    logic          rd_en;
    logic          rd_bank;
    logic          swap_ack;
    logic [AB-1:0] rd_addr;
    logic [PB-1:0] rd_data  = '0;

    frame_buffer_streamer_if #(.PIXEL_BITS(PB)) sif ();

    frame_buffer_streamer #(
        .NUM_PIXELS (N),
        .PIXEL_BITS (PB),
        .ADDR_BITS  (AB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_bank  (rd_bank),
        .rd_data  (rd_data),
        .swap_req (swap_req),
        .swap_ack (swap_ack),
        .out_if   (sif)
    );

    always #5 clk = ~clk;

    // Two-bank frame memory with a one-cycle synchronous read.
    logic [PB-1:0] bram [2][N];
    always @(posedge clk) begin
        if (rd_en) rd_data <= bram[rd_bank][rd_addr[5:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: reads and beats are numbered from reset; beat k is
    // pixel k%N of frame k/N, and each frame has one bank decided at its last read.
    int   issue_cnt  = 0;
    int   beat_cnt   = 0;
    logic bank_of_frame [256];
    bit   pend       = 0;
    bit   ack_exp    = 0;
    bit   prev_issue = 0;
    bit   after_rst  = 0;
    bit   full_rate  = 0;
    int   ready_mode = 0;
    int   stall_left = 0;

    always @(negedge clk) begin : monitor
        int            idx;
        int            frm;
        int            outstanding;
        int            pop;
        bit            consumed;
        bit            ack_next;
        logic [PB-1:0] exp_pix;
        if (reset) begin
            check_eq("rd_en_in_reset", rd_en, 0);
            issue_cnt        = 0;
            beat_cnt         = 0;
            bank_of_frame[0] = 1'b0;
            pend             = 0;
            ack_exp          = 0;
            prev_issue       = 0;
            after_rst        = 1;
        end else begin
            if (after_rst) begin
                check_eq("rst_rd_addr", rd_addr, 0);
                check_eq("rst_rd_bank", rd_bank, 0);
                check_eq("rst_out_sop", sif.out_sop, 0);
                check_eq("rst_out_eop", sif.out_eop, 0);
                after_rst = 0;
            end
            check_eq("swap_ack", swap_ack, ack_exp);
            outstanding = issue_cnt - beat_cnt;
            pop         = (sif.out_valid && sif.out_ready) ? 1 : 0;
            check_eq("occupancy_ok", outstanding <= DEPTH, 1);
            check_eq("out_valid", sif.out_valid, (outstanding - int'(prev_issue)) > 0);
            check_eq("rd_en", rd_en, (outstanding - pop) < DEPTH);
            if (full_rate) check_eq("full_rate_valid", sif.out_valid, 1);

            consumed = 0;
            ack_next = 0;
            if (rd_en) begin
                idx = issue_cnt % N;
                frm = issue_cnt / N;
                check_eq("rd_addr", rd_addr, idx);
                check_eq("rd_bank", rd_bank, bank_of_frame[frm % 256]);
                if (idx == N - 1) begin
                    if (pend || swap_req) begin
                        bank_of_frame[(frm + 1) % 256] = !bank_of_frame[frm % 256];
                        pend     = 0;
                        ack_next = 1;
                        consumed = 1;
                    end else begin
                        bank_of_frame[(frm + 1) % 256] = bank_of_frame[frm % 256];
                    end
                end
                issue_cnt++;
            end
            if (swap_req && !consumed) pend = 1;
            ack_exp    = ack_next;
            prev_issue = rd_en;

            if (sif.out_valid) begin
                idx     = beat_cnt % N;
                frm     = beat_cnt / N;
                exp_pix = bram[bank_of_frame[frm % 256]][idx];
                check_eq("out_data", sif.out_data, exp_pix);
                check_eq("out_sop", sif.out_sop, idx == 0);
                check_eq("out_eop", sif.out_eop, idx == N - 1);
                if (sif.out_ready) beat_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        swap_req = 1'b0;
        case (ready_mode)
            0: sif.out_ready = 1'b1;
            1: sif.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (sif.out_valid && sif.out_eop && stall_left > 0) begin
                    sif.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    sif.out_ready = 1'b1;
                end
            end
        endcase
        #1;
    endtask

    task automatic wait_issue(input int addr);
        bit found = 0;
        for (int k = 0; k < 8 * N && !found; k++) begin
            tick();
            if (rd_en && rd_addr == AB'(addr)) found = 1;
        end
        check_eq("wait_issue_found", found, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++)
                bram[b][a] = PB'($urandom);
        sif.out_ready = 1'b1;
        repeat (3) tick();

        // Full rate from reset: latency and two back-to-back frames.
        reset = 1'b0;
        #1;
        check_eq("lat_c0_rd_en", rd_en, 1);
        tick();
        check_eq("lat_c1_valid", sif.out_valid, 0);
        tick();
        check_eq("lat_c2_valid", sif.out_valid, 1);
        check_eq("lat_c2_sop", sif.out_sop, 1);
        full_rate = 1;
        repeat (2 * N) tick();
        full_rate = 0;
        check_eq("two_frames_beats", beat_cnt >= 2 * N, 1);

        // Random back-pressure.
        ready_mode = 1;
        repeat (4 * N) tick();

        // Swap requested mid-frame, with a redundant request while pending.
        ready_mode = 0;
        wait_issue(10);
        swap_req = 1'b1;
        wait_issue(20);
        swap_req = 1'b1;
        repeat (3 * N) tick();

        // Swap request coincident with the last read of a frame.
        wait_issue(N - 1);
        swap_req = 1'b1;
        repeat (2 * N) tick();

        // Hold the EOP beat for 20 cycles.
        ready_mode = 2;
        stall_left = 20;
        for (int k = 0; k < 3 * N && stall_left > 0; k++) tick();
        check_eq("stall_done", stall_left, 0);
        check_eq("held_eop", sif.out_eop, 1);
        tick();
        check_eq("eop_release", sif.out_eop && sif.out_valid, 1);
        tick();
        check_eq("sop_after_stall_valid", sif.out_valid, 1);
        check_eq("sop_after_stall", sif.out_sop, 1);
        ready_mode = 0;
        repeat (N) tick();

        // One-cycle reset mid-frame with a read in flight.
        wait_issue(20);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_rst_valid", sif.out_valid, 0);
        check_eq("post_rst_rd_addr", rd_addr, 0);
        ready_mode = 1;
        repeat (3 * N) tick();
        ready_mode = 0;
        repeat (N) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
